branch_predictor_gshare: RTL and testbench
==========================================

# branch_predictor_gshare

Global-history (gshare) branch predictor that answers the prediction requests branch_controller issues when a branch is decoded, and absorbs the resolution feedback it forwards from EX. Holds a table of 2-bit saturating counters indexed by PC XOR global history, plus a committed global history register (GHR). Clears its table with a post-reset sweep FSM and counts mispredictions for statistics.

## Interface
Parameters:
- INDEX_WIDTH, 8, log2 of counter-table entries (256).
- GHR_WIDTH, 8, global history length; must satisfy 1 ≤ GHR_WIDTH ≤ INDEX_WIDTH.
- MISS_CNT_WIDTH, 16, width of the misprediction counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- i_req_valid  in  1  DEC requests a prediction this cycle.
- i_req_pc  in  `ADDR_WIDTH  PC of the decoded branch.
- o_req_prediction  out  1  branch_prediction_t, TAKEN or NOT_TAKEN.
- o_ready  out  1  sweep complete; table valid.
- i_fb_valid  in  1  EX resolved a conditional branch this cycle.
- i_fb_pc  in  `ADDR_WIDTH  PC of the resolved branch.
- i_fb_prediction  in  1  prediction carried down the pipe with the branch.
- i_fb_outcome  in  1  actual outcome (TAKEN/NOT_TAKEN).
- o_miss_count  out  MISS_CNT_WIDTH  saturating mispredict count.

## Operation
- Index: idx(pc) = pc[INDEX_WIDTH+1:2] XOR zero-extended GHR.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Prediction = TAKEN iff bit 1 is set.
- FSM states:
  - INIT: writes 01 to entry sweep_ptr, then increments sweep_ptr. Leaves for RUN after writing entry 2^INDEX_WIDTH−1.
  - RUN: normal operation. Terminal until reset.
- In INIT:
  - o_ready = 0.
  - o_req_prediction = NOT_TAKEN.
  - Feedback is ignored; GHR and o_miss_count are held.
- Update in RUN with i_fb_valid:
  - Counter at idx(i_fb_pc), computed with the current GHR: +1 on TAKEN, −1 on NOT_TAKEN, saturating at 11 and 00.
  - GHR ← {GHR[GHR_WIDTH−2:0], outcome==TAKEN}.
  - o_miss_count increments, saturating at all-ones, when i_fb_prediction ≠ i_fb_outcome.
- GHR is committed-only; prediction never speculatively shifts it.
- Same-cycle forwarding when i_req_valid and i_fb_valid are both high in RUN:
  - The request index uses the post-update GHR.
  - If the request index equals the update index, the prediction uses the post-update counter value.
  - Either way, the prediction equals what a read in the next cycle would return.
- i_req_valid is advisory. The output is computed combinationally from i_req_pc regardless, and the table is never modified by requests.
- Unknown or don't-care feedback fields are never sampled when i_fb_valid = 0.

## Timing
- Reset values:
  - FSM = INIT, sweep_ptr = 0, GHR = 0, o_miss_count = 0.
  - o_ready = 0, o_req_prediction = NOT_TAKEN.
- Sweep takes exactly 2^INDEX_WIDTH rising edges after rst_n deasserts. o_ready is registered and rises after the edge that writes the last entry.
- Prediction is a zero-latency combinational path from i_req_pc, i_fb_* and the state. Updates become architecturally visible at the next rising edge (same cycle via forwarding).
- Reset asserted mid-sweep or mid-run: the table contents are don't-care, all registers return to their reset values immediately, and the sweep restarts from entry 0.
- sweep_ptr wraps only by the transition to RUN; it is never reused.

## Structure
- mips_core_pkg holds:
  - branch_prediction_t (existing).
  - New typedef bp_counter_t (logic [1:0]).
  - Constants BP_CNT_WEAK_NT = 2'b01 and BP_CNT_MAX = 2'b11.
- One sub-module, bp_counter_table:
  - 2^INDEX_WIDTH × 2-bit storage with one combinational read port and one synchronous write port.
  - No reset on the storage itself; clearing is owned by the INIT sweep.
  - Write-to-read forwarding lives in the parent.
- The FSM, GHR, saturating arithmetic and miss counter live in branch_predictor_gshare.

## Test plan
- Reset sweep: release rst_n, idle → o_ready low for exactly 256 edges, then high. Every PC then predicts NOT_TAKEN (01 everywhere). Feedback during INIT leaves GHR = 0 and o_miss_count = 0.
- Training with INDEX_WIDTH=GHR_WIDTH=2, PC 0x0: feedback TAKEN, TAKEN, TAKEN, TAKEN → GHR reaches 4'b…1111 (masked to 11). The entry at idx = 0 XOR 11 = 3 climbs 01→10→11. After this, requests to 0x0 predict TAKEN and the entry stays at 11 (saturation).
- Misprediction counting: 5 feedbacks with prediction ≠ outcome and 3 with prediction = outcome → o_miss_count = 5. With MISS_CNT_WIDTH=2, 5 mispredicts → count holds at 3.
- Same-cycle forwarding: entry at 01, feedback TAKEN on PC X and request on PC X in the same cycle, with both indices equal after the GHR shift → o_req_prediction = TAKEN in that cycle.
- Alternating pattern T,N,T,N… on one PC for 40 resolutions with GHR_WIDTH=2 → the final 16 predictions all correct; o_miss_count stops increasing.
- Reset mid-run: trained table, assert rst_n low for 1 cycle → o_ready = 0 at once, GHR = 0, o_miss_count = 0, and a full 256-cycle sweep follows.

Source files
------------

// File: rtl/branch_predictor_gshare_pkg.sv
// Shared types and constants for the gshare branch predictor: prediction
// encoding, 2-bit counter type, FSM states and the saturating counter step.
package branch_predictor_gshare_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } branch_prediction_t;

  typedef logic [1:0] bp_counter_t;

  localparam bp_counter_t BP_CNT_MIN     = 2'b00;
  localparam bp_counter_t BP_CNT_WEAK_NT = 2'b01;
  localparam bp_counter_t BP_CNT_MAX     = 2'b11;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_t;

  // Move a counter one step toward the resolved outcome, pinning at both ends.
  function automatic bp_counter_t bpCounterStep(input bp_counter_t cnt, input logic taken);
    bp_counter_t result;
    result = cnt;
    if (taken && (cnt != BP_CNT_MAX)) begin
      result = cnt + 2'd1;
    end else if (!taken && (cnt != BP_CNT_MIN)) begin
      result = cnt - 2'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/branch_predictor_gshare_table.sv
// Counter storage: 2^INDEX_WIDTH x 2-bit entries, one combinational read port
// and one synchronous write port. Clearing is done by the parent's sweep.
module bp_counter_table
  import branch_predictor_gshare_pkg::*;
#(
  parameter int INDEX_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   i_wr_en,
  input  logic [INDEX_WIDTH-1:0] i_wr_idx,
  input  logic [1:0]             i_wr_data,
  input  logic [INDEX_WIDTH-1:0] i_rd_idx,
  output logic [1:0]             o_rd_data
);

  bp_counter_t r_mem [2**INDEX_WIDTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare predictor: counters indexed by PC XOR committed global history,
// cleared by a post-reset sweep, with a saturating misprediction counter.
module branch_predictor_gshare
  import branch_predictor_gshare_pkg::*;
#(
  parameter int INDEX_WIDTH    = 8,
  parameter int GHR_WIDTH      = 8,
  parameter int MISS_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_req_valid,
  input  logic [ADDR_WIDTH-1:0]     i_req_pc,
  output logic                      o_req_prediction,
  output logic                      o_ready,
  input  logic                      i_fb_valid,
  input  logic [ADDR_WIDTH-1:0]     i_fb_pc,
  input  logic                      i_fb_prediction,
  input  logic                      i_fb_outcome,
  output logic [MISS_CNT_WIDTH-1:0] o_miss_count
);

  bp_state_t                 r_state;
  bp_state_t                 w_stateNext;
  logic [INDEX_WIDTH-1:0]    r_sweepPtr;
  logic [GHR_WIDTH-1:0]      r_ghr;
  logic [MISS_CNT_WIDTH-1:0] r_missCount;
  logic                      r_ready;

  logic [GHR_WIDTH:0]        w_ghrShift;
  logic [GHR_WIDTH-1:0]      w_ghrNext;
  logic [GHR_WIDTH-1:0]      w_ghrReq;
  logic [INDEX_WIDTH-1:0]    w_ghrExt;
  logic [INDEX_WIDTH-1:0]    w_ghrReqExt;
  logic [INDEX_WIDTH-1:0]    w_fbIdx;
  logic [INDEX_WIDTH-1:0]    w_reqIdx;
  logic [INDEX_WIDTH-1:0]    w_wrIdx;
  logic [1:0]                w_wrData;
  logic [1:0]                w_fbCnt;
  logic [1:0]                w_fbCntNext;
  logic [1:0]                w_reqCnt;
  logic [1:0]                w_predCnt;
  logic                      w_wrEn;
  logic                      w_fbUpdate;
  logic                      w_miss;
  branch_prediction_t        w_prediction;
  logic                      w_unused;

  assign w_unused = ^{i_req_valid, i_req_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], i_req_pc[1:0],
                      i_fb_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], i_fb_pc[1:0]};

  assign w_fbUpdate = (r_state == BP_RUN) && i_fb_valid;
  assign w_ghrShift = {r_ghr, i_fb_outcome};
  assign w_ghrNext  = w_ghrShift[GHR_WIDTH-1:0];
  assign w_ghrReq   = w_fbUpdate ? w_ghrNext : r_ghr;

  always_comb begin
    w_ghrExt                     = '0;
    w_ghrReqExt                  = '0;
    w_ghrExt[GHR_WIDTH-1:0]      = r_ghr;
    w_ghrReqExt[GHR_WIDTH-1:0]   = w_ghrReq;
  end

  assign w_fbIdx     = i_fb_pc[INDEX_WIDTH+1:2] ^ w_ghrExt;
  assign w_reqIdx    = i_req_pc[INDEX_WIDTH+1:2] ^ w_ghrReqExt;
  assign w_fbCntNext = bpCounterStep(w_fbCnt, i_fb_outcome);

  always_comb begin
    w_stateNext = r_state;
    w_wrEn      = 1'b0;
    w_wrIdx     = w_fbIdx;
    w_wrData    = w_fbCntNext;
    case (r_state)
      BP_INIT: begin
        w_wrEn   = 1'b1;
        w_wrIdx  = r_sweepPtr;
        w_wrData = BP_CNT_WEAK_NT;
        if (r_sweepPtr == '1) begin
          w_stateNext = BP_RUN;
        end
      end
      BP_RUN: begin
        w_wrEn = i_fb_valid;
      end
    endcase
  end

  // Replicated storage gives the request and the update each their own read port.
  bp_counter_table #(.INDEX_WIDTH(INDEX_WIDTH)) u_reqTable (
    .clk       (clk),
    .i_wr_en   (w_wrEn),
    .i_wr_idx  (w_wrIdx),
    .i_wr_data (w_wrData),
    .i_rd_idx  (w_reqIdx),
    .o_rd_data (w_reqCnt)
  );

  bp_counter_table #(.INDEX_WIDTH(INDEX_WIDTH)) u_fbTable (
    .clk       (clk),
    .i_wr_en   (w_wrEn),
    .i_wr_idx  (w_wrIdx),
    .i_wr_data (w_wrData),
    .i_rd_idx  (w_fbIdx),
    .o_rd_data (w_fbCnt)
  );

  assign w_predCnt    = (w_fbUpdate && (w_reqIdx == w_fbIdx)) ? w_fbCntNext : w_reqCnt;
  assign w_prediction = (r_state == BP_RUN) ? branch_prediction_t'(w_predCnt[1]) : NOT_TAKEN;
  assign w_miss       = w_fbUpdate && (i_fb_prediction != i_fb_outcome);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= BP_INIT;
      r_sweepPtr  <= '0;
      r_ghr       <= '0;
      r_missCount <= '0;
      r_ready     <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_ready <= (w_stateNext == BP_RUN);
      if (r_state == BP_INIT) begin
        r_sweepPtr <= r_sweepPtr + 1'b1;
      end
      if (w_fbUpdate) begin
        r_ghr <= w_ghrNext;
      end
      if (w_miss && (r_missCount != '1)) begin
        r_missCount <= r_missCount + 1'b1;
      end
    end
  end

  assign o_req_prediction = w_prediction;
  assign o_ready          = r_ready;
  assign o_miss_count     = r_missCount;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench: dutA (8/8/16) covers the sweep and reset; dutB (2/2/16) and
// dutC (2/2/2, sharing dutB's inputs) cover training, forwarding and miss counts.
module tb_branch_predictor_gshare;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rstB_n;

  logic        aReqValid, aFbValid, aFbPred, aFbOut;
  logic [31:0] aReqPc, aFbPc;
  logic        aPred, aReady;
  logic [15:0] aMiss;

  logic        bReqValid, bFbValid, bFbPred, bFbOut;
  logic [31:0] bReqPc, bFbPc;
  logic        bPred, bReady, cPred, cReady;
  logic [15:0] bMiss;
  logic [1:0]  cMiss;

  int passCount = 0;
  int checkCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  branch_predictor_gshare dutA (
    .clk(clk), .rst_n(rst_n), .i_req_valid(aReqValid), .i_req_pc(aReqPc),
    .o_req_prediction(aPred), .o_ready(aReady), .i_fb_valid(aFbValid),
    .i_fb_pc(aFbPc), .i_fb_prediction(aFbPred), .i_fb_outcome(aFbOut),
    .o_miss_count(aMiss)
  );

  branch_predictor_gshare #(.INDEX_WIDTH(2), .GHR_WIDTH(2), .MISS_CNT_WIDTH(16)) dutB (
    .clk(clk), .rst_n(rstB_n), .i_req_valid(bReqValid), .i_req_pc(bReqPc),
    .o_req_prediction(bPred), .o_ready(bReady), .i_fb_valid(bFbValid),
    .i_fb_pc(bFbPc), .i_fb_prediction(bFbPred), .i_fb_outcome(bFbOut),
    .o_miss_count(bMiss)
  );

  branch_predictor_gshare #(.INDEX_WIDTH(2), .GHR_WIDTH(2), .MISS_CNT_WIDTH(2)) dutC (
    .clk(clk), .rst_n(rstB_n), .i_req_valid(bReqValid), .i_req_pc(bReqPc),
    .o_req_prediction(cPred), .o_ready(cReady), .i_fb_valid(bFbValid),
    .i_fb_pc(bFbPc), .i_fb_prediction(bFbPred), .i_fb_outcome(bFbOut),
    .o_miss_count(cMiss)
  );

  task automatic applyStimulus(input bit toA, input logic fbValid, input logic [31:0] fbPc,
                               input logic fbPred, input logic fbOut, input logic [31:0] reqPc);
    if (toA) begin
      aReqValid = 1'b1; aReqPc = reqPc;
      aFbValid = fbValid; aFbPc = fbPc; aFbPred = fbPred; aFbOut = fbOut;
    end else begin
      bReqValid = 1'b1; bReqPc = reqPc;
      bFbValid = fbValid; bFbPc = fbPc; bFbPred = fbPred; bFbOut = fbOut;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One resolved branch, held across exactly one rising edge.
  task automatic feedback(input bit toA, input logic [31:0] pc, input logic pred, input logic out);
    @(negedge clk);
    applyStimulus(toA, 1'b1, pc, pred, out, toA ? aReqPc : bReqPc);
    @(posedge clk);
    #1;
    applyStimulus(toA, 1'b0, pc, pred, out, toA ? aReqPc : bReqPc);
  endtask

  task automatic checkPred(input bit toA, input logic [31:0] pc, input logic expected, input string tag);
    applyStimulus(toA, 1'b0, 32'h0, 1'b0, 1'b0, pc);
    #1;
    checkOutput(tag, toA ? {15'd0, aPred} : {15'd0, bPred}, {15'd0, expected});
  endtask

  task automatic resetB();
    @(negedge clk);
    rstB_n = 1'b0;
    #1;
    checkOutput("resetB_ready", {15'd0, bReady}, 16'd0);
    checkOutput("resetB_miss", bMiss, 16'd0);
    @(negedge clk);
    rstB_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("resetB_sweepDone", {15'd0, bReady}, 16'd1);
  endtask

  logic [1:0] missPairs [8];
  logic       altExp;

  initial begin
    rst_n = 1'b0;
    rstB_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_readyA", {15'd0, aReady}, 16'd0);
    checkOutput("rst_predA", {15'd0, aPred}, 16'd0);
    checkOutput("rst_missA", aMiss, 16'd0);
    checkOutput("rst_readyB", {15'd0, bReady}, 16'd0);

    // Sweep with a mispredicted TAKEN feedback held high throughout.
    @(negedge clk);
    rst_n = 1'b1;
    rstB_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0);
    repeat (255) @(posedge clk);
    #1;
    checkOutput("sweep255_ready", {15'd0, aReady}, 16'd0);
    checkOutput("init_predNT", {15'd0, aPred}, 16'd0);
    checkOutput("init_missHeld", aMiss, 16'd0);
    checkOutput("sweepB_ready", {15'd0, bReady}, 16'd1);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("sweep256_ready", {15'd0, aReady}, 16'd1);
    checkOutput("run_missZero", aMiss, 16'd0);
    checkPred(1'b1, 32'h0000_0000, 1'b0, "clear_pc0");
    checkPred(1'b1, 32'h0000_03FC, 1'b0, "clear_pc3fc");
    checkPred(1'b1, 32'h0000_0124, 1'b0, "clear_pc124");
    checkPred(1'b1, 32'hFFFF_FFFC, 1'b0, "clear_pcTop");

    // GHR still zero: TAKEN on PC 0 trains idx 0, then GHR=1 so PC 4 maps to idx 0.
    feedback(1'b1, 32'h0, 1'b1, 1'b1);
    checkPred(1'b1, 32'h4, 1'b1, "ghrZeroAfterInit");
    feedback(1'b1, 32'h80, 1'b1, 1'b0);
    checkOutput("missA_one", aMiss, 16'd1);

    // Training on the small predictor, PC 0.
    feedback(1'b0, 32'h0, 1'b1, 1'b1);
    feedback(1'b0, 32'h0, 1'b1, 1'b1);
    checkPred(1'b0, 32'h0, 1'b0, "train_t2_idx3_01");
    feedback(1'b0, 32'h0, 1'b1, 1'b1);
    checkPred(1'b0, 32'h0, 1'b1, "train_t3_idx3_10");
    feedback(1'b0, 32'h0, 1'b1, 1'b1);
    checkPred(1'b0, 32'h0, 1'b1, "train_t4_idx3_11");

    // GHR=11 and TAKEN keeps it 11, so PC 4 hits idx 2 for both ports.
    checkPred(1'b0, 32'h4, 1'b0, "fwd_before");
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 32'h4);
    #1;
    checkOutput("fwd_sameCycle", {15'd0, bPred}, 16'd1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 32'h4, 1'b1, 1'b1, 32'h4);

    // idx 3 must saturate at 11: two more TAKENs, one NOT_TAKEN leaves 10.
    feedback(1'b0, 32'h0, 1'b1, 1'b1);
    feedback(1'b0, 32'h0, 1'b1, 1'b1);
    feedback(1'b0, 32'h0, 1'b0, 1'b0);
    checkPred(1'b0, 32'h4, 1'b1, "sat_idx3_10");
    checkOutput("train_noMiss", bMiss, 16'd0);

    // Five mispredictions and three correct ones.
    resetB();
    missPairs[0] = 2'b10; missPairs[1] = 2'b01; missPairs[2] = 2'b11; missPairs[3] = 2'b10;
    missPairs[4] = 2'b00; missPairs[5] = 2'b01; missPairs[6] = 2'b10; missPairs[7] = 2'b00;
    for (int i = 0; i < 8; i++) begin
      feedback(1'b0, 32'h0, missPairs[i][1], missPairs[i][0]);
      if (i == 1) checkOutput("missC_two", {14'd0, cMiss}, 16'd2);
    end
    checkOutput("missB_five", bMiss, 16'd5);
    checkOutput("missC_sat", {14'd0, cMiss}, 16'd3);

    // Alternating T,N on PC 0 from a clean table: only resolutions 0 and 2 miss.
    resetB();
    for (int k = 0; k < 40; k++) begin
      altExp = ((k % 2) == 0) && (k >= 4);
      checkPred(1'b0, 32'h0, altExp, "alt_pred");
      feedback(1'b0, 32'h0, altExp, ((k % 2) == 0));
      if (k == 23) checkOutput("alt_miss24", bMiss, 16'd2);
    end
    checkOutput("alt_miss40", bMiss, 16'd2);

    // Mid-run reset of the trained large predictor.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready", {15'd0, aReady}, 16'd0);
    checkOutput("midrst_miss", aMiss, 16'd0);
    checkOutput("midrst_pred", {15'd0, aPred}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (255) @(posedge clk);
    #1;
    checkOutput("resweep255_ready", {15'd0, aReady}, 16'd0);
    @(posedge clk);
    #1;
    checkOutput("resweep256_ready", {15'd0, aReady}, 16'd1);
    checkPred(1'b1, 32'h0, 1'b0, "resweep_tableCleared");
    checkPred(1'b1, 32'h4, 1'b0, "resweep_ghrCleared");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
